// File: rtl/cpu_control_unit.sv
// Hardwired Moore control unit for the single-bus datapath.
// Each instruction is sequenced through fetch (T0-T2), operand (T3-T4) and
// writeback (T5-T6) steps. The unit also handles memory wait states, a stop
// request at the instruction boundary, and halt/illegal-opcode detection.
// Strobes are decoded from the registered state and forced low while Clear is
// low, so the reset takes effect without waiting for a clock edge.
module cpu_control_unit #(
    parameter int NREGS = 16,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Stop,
    input  logic             mem_ready,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             Zlowout,
    output logic             ZHighout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [4:0]       alu_op,
    output logic             Run,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] ST_T0     = 4'd0;
    localparam logic [3:0] ST_T1     = 4'd1;
    localparam logic [3:0] ST_T2     = 4'd2;
    localparam logic [3:0] ST_T3     = 4'd3;
    localparam logic [3:0] ST_T4     = 4'd4;
    localparam logic [3:0] ST_T5     = 4'd5;
    localparam logic [3:0] ST_T6     = 4'd6;
    localparam logic [3:0] ST_IDLE   = 4'd7;
    localparam logic [3:0] ST_HALTED = 4'd8;

    localparam logic [4:0] OP_ALU_LO = 5'b00011;
    localparam logic [4:0] OP_ALU_HI = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_NOP    = 5'b11010;
    localparam logic [4:0] OP_HALT   = 5'b11011;

    // Register fields wrap modulo NREGS so narrower register files still decode.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [3:0] field);
        logic [NREGS-1:0] vec;
        int unsigned      idx;
        idx = 32'(field) % $unsigned(NREGS);
        vec = '0;
        for (int i = 0; i < NREGS; i++) begin
            vec[i] = (idx == $unsigned(i));
        end
        return vec;
    endfunction

    logic [3:0]       state_r;
    logic [3:0]       state_next_s;
    logic             t1_seen_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;
    logic             retire_s;
    logic             set_err_s;
    logic [4:0]       opcode_s;
    logic             is_alu_s;
    logic             is_muldiv_s;
    logic             ir_unused_s;

    assign opcode_s    = IR[31:27];
    assign is_alu_s    = (opcode_s >= OP_ALU_LO) && (opcode_s <= OP_ALU_HI);
    assign is_muldiv_s = (opcode_s == OP_MUL) || (opcode_s == OP_DIV);
    assign ir_unused_s = ^IR[14:0];

    // Next-state logic; also flags the retire cycle and illegal-opcode detection.
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        set_err_s    = 1'b0;
        case (state_r)
            ST_T0: state_next_s = ST_T1;
            ST_T1: begin
                if (mem_ready) begin
                    state_next_s = ST_T2;
                end else begin
                    state_next_s = ST_T1;
                end
            end
            ST_T2: state_next_s = ST_T3;
            ST_T3: begin
                if (opcode_s == OP_NOP) begin
                    retire_s     = 1'b1;
                    state_next_s = Stop ? ST_IDLE : ST_T0;
                end else if (opcode_s == OP_HALT) begin
                    retire_s     = 1'b1;
                    state_next_s = ST_HALTED;
                end else if (is_alu_s || is_muldiv_s) begin
                    state_next_s = ST_T4;
                end else begin
                    set_err_s    = 1'b1;
                    state_next_s = ST_HALTED;
                end
            end
            ST_T4: state_next_s = ST_T5;
            ST_T5: begin
                if (is_muldiv_s) begin
                    state_next_s = ST_T6;
                end else begin
                    retire_s     = 1'b1;
                    state_next_s = Stop ? ST_IDLE : ST_T0;
                end
            end
            ST_T6: begin
                retire_s     = 1'b1;
                state_next_s = Stop ? ST_IDLE : ST_T0;
            end
            ST_IDLE: begin
                if (Stop) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_T0;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_T0;
        endcase
    end

    // State register plus retire counter, sticky error and the T1-repeat flag.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_r   <= ST_T0;
            t1_seen_r <= 1'b0;
            count_r   <= '0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            t1_seen_r <= (state_r == ST_T1) && (state_next_s == ST_T1);
            if (retire_s) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    logic [13:0]      strb_s;
    logic [NREGS-1:0] rin_s;
    logic [NREGS-1:0] rout_s;
    logic [4:0]       alu_s;
    logic             run_s;

    // Moore decode of the current state into datapath strobes and register selects.
    always_comb begin
        strb_s = 14'd0;
        rin_s  = '0;
        rout_s = '0;
        alu_s  = 5'd0;
        run_s  = 1'b1;
        // strb_s: {PCout,Zlowout,ZHighout,MDRout,MARin,PCin,MDRin,IRin,Yin,Zin,HIin,LOin,IncPC,Read}
        case (state_r)
            ST_T0: strb_s = 14'b1000_1000_0100_10;
            ST_T1: strb_s = {1'b0, 1'b1, 3'b000, !t1_seen_r, 1'b1, 6'b000000, 1'b1};
            ST_T2: strb_s = 14'b0001_0001_0000_00;
            ST_T3: begin
                if (is_alu_s || is_muldiv_s) begin
                    strb_s = 14'b0000_0000_1000_00;
                    rout_s = reg_onehot(IR[22:19]);
                end else begin
                    strb_s = 14'd0;
                end
            end
            ST_T4: begin
                strb_s = 14'b0000_0000_0100_00;
                rout_s = reg_onehot(IR[18:15]);
                alu_s  = opcode_s;
            end
            ST_T5: begin
                if (is_muldiv_s) begin
                    strb_s = 14'b0100_0000_0001_00;
                end else begin
                    strb_s = 14'b0100_0000_0000_00;
                    rin_s  = reg_onehot(IR[26:23]);
                end
            end
            ST_T6:     strb_s = 14'b0010_0000_0010_00;
            ST_IDLE:   run_s  = 1'b0;
            ST_HALTED: run_s  = 1'b0;
            default:   run_s  = 1'b0;
        endcase
    end

    assign {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin,
            IRin, Yin, Zin, HIin, LOin, IncPC, Read} = strb_s & {14{Clear}};
    assign Rin         = rin_s & {NREGS{Clear}};
    assign Rout        = rout_s & {NREGS{Clear}};
    assign alu_op      = alu_s & {5{Clear}};
    assign Run         = run_s & Clear;
    assign err         = err_r;
    assign instr_count = count_r;

endmodule
